ft_mode245_tx_engine: RTL and testbench
=======================================

Name: ft_mode245_tx_engine

Overview:
- Single-clock transmit engine for the FTDI FT600/FT601 245 synchronous FIFO bus. It runs entirely in the `ft_clk` domain.
- Generalised successor of the fixed 16-bit TX path:
  - bus width of 16 or 32 bits;
  - parametrised buffer depth;
  - bounded burst length;
  - per-word byte enables for short final words;
  - packet-end (`tx_last`) burst termination.
- Sits between a local producer (e.g. a counter feeder) and the FT chip pins. The read side of the bus is held idle.

Parameters:
- DATA_WIDTH, 16, FT bus width; 16 (FT600) or 32 (FT601). Any other value is a compile-time error.
- BUF_WIDTH, 3, log2 of TX buffer depth (depth = 2**BUF_WIDTH words).
- MAX_BURST, 64, maximum words per write burst before WR is released. Range 1..65535.
- GAP_CYCLES, 1, idle cycles forced between bursts. Range 1..15.

Ports:
- `clk`  in  1  `ft_clk`, the sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous active-low reset (0 = reset, sampled on `clk`).
- `tx_en`  in  1  producer write strobe; ignored while `tx_full`=1.
- `tx_in`  in  DATA_WIDTH  producer data word.
- `tx_be`  in  DATA_WIDTH/8  byte enables for this word; bit i qualifies byte i.
- `tx_last`  in  1  word ends a packet; the burst terminates after it.
- `tx_full`  out  1  buffer full.
- `tx_level`  out  BUF_WIDTH+1  words currently buffered.
- `ft_data`  out  DATA_WIDTH  data to pins.
- `ft_be`  out  DATA_WIDTH/8  byte enables to pins.
- `ft_data_oe`  out  1  pad output-enable for `ft_data`/`ft_be`.
- `ft_txe`  in  1  active-low: chip FIFO has space.
- `ft_wr`  out  1  active-low write strobe.
- `ft_oe`  out  1  active-low; held 1.
- `ft_rd`  out  1  active-low; held 1.

Behaviour:
- Reset values (`rst`=0 at an edge):
  - `ft_wr`=1, `ft_oe`=1, `ft_rd`=1, `ft_data_oe`=0;
  - `ft_data`=0, `ft_be`=0;
  - `tx_full`=0, `tx_level`=0;
  - buffer emptied, state IDLE, burst and gap counters 0.
- Reset mid-burst drops buffered words and releases WR on the same edge.
- Buffer:
  - Show-ahead FIFO holding {`tx_last`, `tx_be`, `tx_in`}.
  - Write when `tx_en` && !`tx_full`.
  - `tx_full`/`tx_level` are registered and update the cycle after the push/pop.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo depth; full/empty are distinguished by the extra pointer bit.
- Transfer rule: a word is transferred at an edge where `ft_wr`=0 AND `ft_txe`=0. Only then is it popped and the burst count incremented.
  - With `ft_wr`=0 and `ft_txe`=1, the word is NOT transferred.
  - `ft_data`/`ft_be` hold that word; it is re-presented when `ft_txe` returns low within the same burst, or at the start of the next burst after a gap.
- `ft_data`, `ft_be` and `ft_wr` are registered. `ft_data`/`ft_be` show the FIFO head whenever `ft_data_oe`=1.
- States:
  - IDLE: `ft_wr`=1, `ft_data_oe`=0.
    - If `ft_txe`=0 and buffer non-empty → BURST.
    - `ft_data_oe`=1 and `ft_wr`=0 are asserted on the transition edge, so the first transfer can occur one cycle after `ft_txe` low is seen.
  - BURST: `ft_wr`=0, `ft_data_oe`=1.
    - → GAP when, at an edge, any of the following holds:
      - a transfer of a `tx_last` word;
      - the transfer count reaches MAX_BURST;
      - the buffer would be empty after this edge's pop;
      - `ft_txe`=1.
    - `ft_wr` deasserts on that edge and the burst count clears.
  - GAP: `ft_wr`=1, `ft_data_oe`=0 for GAP_CYCLES cycles, then → IDLE.
- Simultaneous events: with `ft_txe` rising and a `tx_last` transfer requested on the same edge, no transfer occurs (`ft_txe`=1) and the word remains buffered.
- Byte enables are passed through unmodified. A word with `tx_be`=0 is still transferred (zero-length-packet marker).

Optional Feature:
- Macro FT_TX_STATS_EN adds outputs:
  - `stat_words` (32): transferred-word counter;
  - `stat_stalls` (32): cycles with `ft_wr`=0 && `ft_txe`=1.
- Both counters saturate at all-ones and clear on reset.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- Package `ft_mode245_pkg` holds:
  - state encoding (IDLE/BURST/GAP);
  - `BE_WIDTH` = DATA_WIDTH/8 helper;
  - the FIFO entry field offsets.
- One sub-module, `ft_tx_fifo`: synchronous show-ahead FIFO parametrised by width and BUF_WIDTH, with full/empty/level outputs.

Test Plan:
- Reset held 5 cycles with `tx_en` pulsed → `ft_wr`=1, `ft_data_oe`=0, `tx_level`=0 throughout; release leaves the buffer empty.
- DATA_WIDTH=16, push 0x0001..0x0008 with `ft_txe`=1 → `tx_full`=1 after the 8th push and a 9th push is ignored. Then drop `ft_txe` → 8 transfers in order on consecutive edges, `ft_wr` high after the 8th.
- MAX_BURST=4, GAP_CYCLES=2, 8 words, `ft_txe`=0 → bursts of 4 transfers separated by 2 cycles `ft_wr`=1 plus 1 IDLE cycle.
- `ft_txe` high for 3 cycles mid-burst at word 0x0005 → 0x0005 is not popped and reappears first on the next burst; no word is lost or duplicated.
- DATA_WIDTH=32, words 0xAABBCCDD (`tx_be`=1111) and 0x000000EE (`tx_be`=0001, `tx_last`=1), 3 more words queued → `ft_be`=0001 on the second word, burst ends after it, and the remaining words go in a new burst.
- FT_TX_STATS_EN defined, 10 transfers with 4 stall cycles → `stat_words`=10, `stat_stalls`=4.

Source files
------------

// File: rtl/ft_mode245_pkg.sv
// Shared definitions for the FT600/FT601 245-mode transmit engine:
// FSM state encoding, byte-enable width helper and FIFO entry layout.
package ft_mode245_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    // One byte-enable bit per bus byte.
    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // FIFO entry layout, LSB first: {last, be, data}.
    localparam int unsigned ENT_DATA_LSB = 0;

    function automatic int unsigned ent_be_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned ent_last_bit(input int unsigned dw);
        return dw + dw / 8;
    endfunction

    function automatic int unsigned ent_width(input int unsigned dw);
        return dw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/ft_tx_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable. full/empty/level are registered; rd_data_next is
// the entry that will sit at the head after the current edge, so the consumer
// can register it and present the head with no extra latency.
module ft_tx_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data_next,
    output logic                 full,
    output logic                 empty,
    output logic                 empty_next,
    output logic [BUF_WIDTH:0]   level
);

    localparam int unsigned DEPTH = 2 ** BUF_WIDTH;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [BUF_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [BUF_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [BUF_WIDTH:0]   level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 push, pop;
    logic [BUF_WIDTH-1:0] wr_idx, rd_idx_next;

    // Pointer advance, next flags and next-head lookahead.
    always_comb begin
        push        = wr_en && !full_q;
        pop         = rd_en && !empty_q;
        wr_ptr_d    = wr_ptr_q + {{BUF_WIDTH{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{BUF_WIDTH{1'b0}}, pop};
        wr_idx      = wr_ptr_q[BUF_WIDTH-1:0];
        rd_idx_next = rd_ptr_d[BUF_WIDTH-1:0];
        empty_d     = (wr_ptr_d == rd_ptr_d);
        full_d      = (wr_ptr_d[BUF_WIDTH] != rd_ptr_d[BUF_WIDTH]) &&
                      (wr_ptr_d[BUF_WIDTH-1:0] == rd_ptr_d[BUF_WIDTH-1:0]);
        level_d     = wr_ptr_d - rd_ptr_d;
        // Index match with a push only happens when the new word becomes the
        // sole entry, so bypass it straight to the head.
        rd_data_next = (push && (wr_idx == rd_idx_next)) ? wr_data : mem_q[rd_idx_next];
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign empty_next = empty_d;
    assign level      = level_q;

endmodule

// File: rtl/ft_mode245_tx_engine.sv
// FT600/FT601 245 synchronous FIFO transmit engine, single ft_clk domain.
// Buffers producer words, then writes them to the chip in bounded bursts
// separated by forced idle gaps. Optional macro FT_TX_STATS_EN adds
// saturating transferred-word and stall-cycle counters.
module ft_mode245_tx_engine
    import ft_mode245_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUF_WIDTH  = 3,
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_en,
    input  logic [DATA_WIDTH-1:0]   tx_in,
    input  logic [DATA_WIDTH/8-1:0] tx_be,
    input  logic                    tx_last,
    output logic                    tx_full,
    output logic [BUF_WIDTH:0]      tx_level,
    output logic [DATA_WIDTH-1:0]   ft_data,
    output logic [DATA_WIDTH/8-1:0] ft_be,
    output logic                    ft_data_oe,
    input  logic                    ft_txe,
    output logic                    ft_wr,
    output logic                    ft_oe,
    output logic                    ft_rd
`ifdef FT_TX_STATS_EN
    ,
    output logic [31:0]             stat_words,
    output logic [31:0]             stat_stalls
`endif
);

    localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);
    localparam int unsigned ENT_W    = ent_width(DATA_WIDTH);
    localparam int unsigned BE_LSB   = ent_be_lsb(DATA_WIDTH);
    localparam int unsigned LAST_BIT = ent_last_bit(DATA_WIDTH);
    localparam logic [15:0] MAX_BURST_C = 16'(MAX_BURST);
    localparam logic [3:0]  GAP_LAST_C  = 4'(GAP_CYCLES - 1);

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
        $error("ft_mode245_tx_engine: DATA_WIDTH must be 16 or 32");
    end
    if (MAX_BURST < 1 || MAX_BURST > 65535) begin : g_bad_burst
        $error("ft_mode245_tx_engine: MAX_BURST must be 1..65535");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("ft_mode245_tx_engine: GAP_CYCLES must be 1..15");
    end

    tx_state_t             state_q, state_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic                  ft_wr_q, ft_wr_d;
    logic                  data_oe_q, data_oe_d;
    logic [DATA_WIDTH-1:0] ft_data_q, ft_data_d;
    logic [BE_WIDTH-1:0]   ft_be_q, ft_be_d;
    logic                  head_last_q, head_last_d;

    logic [ENT_W-1:0]      fifo_head_next;
    logic                  fifo_full, fifo_empty, fifo_empty_next;
    logic                  xfer;

    // A word moves only on an edge where WR is low and the chip has room.
    assign xfer = !ft_wr_q && !ft_txe;

    ft_tx_fifo #(
        .WIDTH     (ENT_W),
        .BUF_WIDTH (BUF_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (tx_en),
        .wr_data      ({tx_last, tx_be, tx_in}),
        .rd_en        (xfer),
        .rd_data_next (fifo_head_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .empty_next   (fifo_empty_next),
        .level        (tx_level)
    );

    // Burst FSM next-state and registered pin values.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        ft_wr_d     = 1'b1;
        data_oe_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ft_txe && !fifo_empty) begin
                    state_d     = ST_BURST;
                    burst_cnt_d = '0;
                    ft_wr_d     = 1'b0;
                    data_oe_d   = 1'b1;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                end
                // With ft_txe low every other term describes this edge's transfer.
                if (ft_txe || head_last_q || (burst_cnt_q + 16'd1 == MAX_BURST_C) ||
                    fifo_empty_next) begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = '0;
                    burst_cnt_d = '0;
                end else begin
                    ft_wr_d   = 1'b0;
                    data_oe_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST_C) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        head_last_d = fifo_head_next[LAST_BIT];
        ft_data_d   = data_oe_d ? fifo_head_next[ENT_DATA_LSB +: DATA_WIDTH] : '0;
        ft_be_d     = data_oe_d ? fifo_head_next[BE_LSB +: BE_WIDTH] : '0;
    end

    // FSM and pin registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            ft_wr_q     <= 1'b1;
            data_oe_q   <= 1'b0;
            ft_data_q   <= '0;
            ft_be_q     <= '0;
            head_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ft_wr_q     <= ft_wr_d;
            data_oe_q   <= data_oe_d;
            ft_data_q   <= ft_data_d;
            ft_be_q     <= ft_be_d;
            head_last_q <= head_last_d;
        end
    end

    assign tx_full    = fifo_full;
    assign ft_data    = ft_data_q;
    assign ft_be      = ft_be_q;
    assign ft_data_oe = data_oe_q;
    assign ft_wr      = ft_wr_q;
    assign ft_oe      = 1'b1;
    assign ft_rd      = 1'b1;

`ifdef FT_TX_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    // Saturating transfer and stall counters.
    always_comb begin
        stat_words_d  = stat_words_q;
        stat_stalls_d = stat_stalls_q;
        if (xfer && (stat_words_q != '1)) begin
            stat_words_d = stat_words_q + 32'd1;
        end
        if (!ft_wr_q && ft_txe && (stat_stalls_q != '1)) begin
            stat_stalls_d = stat_stalls_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_ft_mode245_tx_engine.sv
// Directed bench: instance A is the 16-bit default build, instance B is a
// 32-bit build with MAX_BURST=4 and GAP_CYCLES=2.
module tb_ft_mode245_tx_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A signals
    logic        a_rst, a_en, a_last, a_txe;
    logic [15:0] a_din;
    logic [1:0]  a_be_in;
    logic        a_full, a_doe, a_wr, a_oe, a_rd;
    logic [3:0]  a_level;
    logic [15:0] a_data;
    logic [1:0]  a_be;

    // Instance B signals
    logic        b_rst, b_en, b_last, b_txe;
    logic [31:0] b_din;
    logic [3:0]  b_be_in;
    logic        b_full, b_doe, b_wr, b_oe, b_rd;
    logic [3:0]  b_level;
    logic [31:0] b_data;
    logic [3:0]  b_be;

`ifdef FT_TX_STATS_EN
    logic [31:0] a_sw, a_ss, b_sw, b_ss;
`endif

    ft_mode245_tx_engine #(
        .DATA_WIDTH (16),
        .BUF_WIDTH  (3),
        .MAX_BURST  (64),
        .GAP_CYCLES (1)
    ) u_a (
        .clk(clk), .rst(a_rst), .tx_en(a_en), .tx_in(a_din), .tx_be(a_be_in),
        .tx_last(a_last), .tx_full(a_full), .tx_level(a_level), .ft_data(a_data),
        .ft_be(a_be), .ft_data_oe(a_doe), .ft_txe(a_txe), .ft_wr(a_wr),
        .ft_oe(a_oe), .ft_rd(a_rd)
`ifdef FT_TX_STATS_EN
        , .stat_words(a_sw), .stat_stalls(a_ss)
`endif
    );

    ft_mode245_tx_engine #(
        .DATA_WIDTH (32),
        .BUF_WIDTH  (3),
        .MAX_BURST  (4),
        .GAP_CYCLES (2)
    ) u_b (
        .clk(clk), .rst(b_rst), .tx_en(b_en), .tx_in(b_din), .tx_be(b_be_in),
        .tx_last(b_last), .tx_full(b_full), .tx_level(b_level), .ft_data(b_data),
        .ft_be(b_be), .ft_data_oe(b_doe), .ft_txe(b_txe), .ft_wr(b_wr),
        .ft_oe(b_oe), .ft_rd(b_rd)
`ifdef FT_TX_STATS_EN
        , .stat_words(b_sw), .stat_stalls(b_ss)
`endif
    );

    // Transfer monitors: record each word that crosses the bus.
    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] d;
    } xfer_t;

    logic [15:0] qa[$];
    logic [15:0] ea[$];
    xfer_t       qb[$];
    xfer_t       eb[$];

    always @(posedge clk) begin
        if (a_rst && !a_wr && !a_txe) qa.push_back(a_data);
        if (b_rst && !b_wr && !b_txe) qb.push_back({b_be, b_data});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_qa(input string tag);
        chk({tag, "_count"}, 64'(qa.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < qa.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(qa[i]), 64'(ea[i]));
        qa.delete();
        ea.delete();
    endtask

    task automatic cmp_qb(input string tag);
        chk({tag, "_count"}, 64'(qb.size()), 64'(eb.size()));
        for (int i = 0; i < eb.size() && i < qb.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(qb[i]), 64'(eb[i]));
        qb.delete();
        eb.delete();
    endtask

    task automatic a_step(input logic en, input logic [15:0] din, input logic txe);
        a_en = en; a_din = din; a_txe = txe; a_be_in = 2'b11; a_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic b_step(input logic en, input logic [31:0] din, input logic [3:0] be,
                          input logic last, input logic txe);
        b_en = en; b_din = din; b_be_in = be; b_last = last; b_txe = txe;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] din;
        logic        txe;
        logic        exp_wr;
        logic        exp_doe;
        logic [15:0] exp_data;
        logic        exp_full;
        logic [3:0]  exp_level;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic en, input logic [15:0] din,
                           input logic txe, input logic exp_wr, input logic exp_doe,
                           input logic [15:0] exp_data, input logic exp_full,
                           input logic [3:0] exp_level);
        vec_t v;
        v.rst = rst; v.en = en; v.din = din; v.txe = txe;
        v.exp_wr = exp_wr; v.exp_doe = exp_doe; v.exp_data = exp_data;
        v.exp_full = exp_full; v.exp_level = exp_level;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] act, exp;
        logic        chk_data;
        logic [11:0] wr_seq;
        int          txe_pat[21];

        a_rst = 1'b0; a_en = 1'b0; a_din = '0; a_be_in = 2'b11; a_last = 1'b0; a_txe = 1'b1;
        b_rst = 1'b0; b_en = 1'b0; b_din = '0; b_be_in = '0; b_last = 1'b0; b_txe = 1'b1;

        // ---- Table: reset with tx_en pulsed, fill to full, drain in one burst
        for (int i = 0; i < 5; i++) add_vec(0, 1, 16'hDEAD, 1, 1, 0, 16'h0, 0, 4'd0);
        add_vec(1, 0, 16'h0, 1, 1, 0, 16'h0, 0, 4'd0);
        for (int k = 1; k <= 8; k++) add_vec(1, 1, 16'(k), 1, 1, 0, 16'h0, k == 8, 4'(k));
        add_vec(1, 1, 16'h0009, 1, 1, 0, 16'h0, 1, 4'd8);
        add_vec(1, 0, 16'h0, 0, 0, 1, 16'h0001, 1, 4'd8);
        for (int k = 1; k <= 7; k++) add_vec(1, 0, 16'h0, 0, 0, 1, 16'(k + 1), 0, 4'(8 - k));
        add_vec(1, 0, 16'h0, 0, 1, 0, 16'h0, 0, 4'd0);
        add_vec(1, 0, 16'h0, 0, 1, 0, 16'h0, 0, 4'd0);
        add_vec(1, 0, 16'h0, 1, 1, 0, 16'h0, 0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst = vecs[i].rst; a_en = vecs[i].en; a_din = vecs[i].din;
            a_txe = vecs[i].txe; a_be_in = 2'b11; a_last = 1'b0;
            @(posedge clk); #1;
            chk_data = vecs[i].exp_doe || !vecs[i].rst;
            act = {a_wr, a_doe, a_oe, a_rd, a_full, a_level, chk_data ? a_data : 16'h0};
            exp = {vecs[i].exp_wr, vecs[i].exp_doe, 1'b1, 1'b1, vecs[i].exp_full,
                   vecs[i].exp_level, chk_data ? vecs[i].exp_data : 16'h0};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
        end
        for (int k = 1; k <= 8; k++) ea.push_back(16'(k));
        cmp_qa("a_fill_drain");

        // ---- A: ft_txe high for 3 cycles while 0x0005 is presented
        for (int k = 1; k <= 8; k++) a_step(1, 16'(k), 1);
        a_step(0, 0, 0);
        chk("a_stall_first", 64'(a_data), 64'h1);
        for (int k = 0; k < 4; k++) a_step(0, 0, 0);
        chk("a_stall_head5", 64'({a_wr, a_data}), 64'h0_0005);
        for (int k = 0; k < 3; k++) begin
            a_step(0, 0, 1);
            chk($sformatf("a_stall_hold%0d", k), 64'({a_wr, a_level}), 64'h14);
        end
        a_step(0, 0, 0);
        chk("a_stall_represent", 64'({a_wr, a_doe, a_data}), 64'h1_0005);
        for (int k = 0; k < 4; k++) a_step(0, 0, 0);
        chk("a_stall_end", 64'({a_wr, a_level}), 64'h10);
        a_step(0, 0, 1);
        for (int k = 1; k <= 8; k++) ea.push_back(16'(k));
        cmp_qa("a_stall");

        // ---- B: reset state on the 32-bit instance
        b_step(0, 0, 0, 0, 1);
        b_step(1, 32'hFFFF_FFFF, 4'hF, 1, 0);
        chk("b_reset", 64'({b_wr, b_doe, b_oe, b_rd, b_full, b_level, b_data, b_be}),
            64'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0}));
        b_rst = 1'b1;
        b_step(0, 0, 0, 0, 1);
        chk("b_reset_level", 64'(b_level), 64'h0);

        // ---- B: MAX_BURST=4, GAP_CYCLES=2, 8 words
        for (int k = 1; k <= 8; k++) begin
            b_step(1, 32'h1000_0000 + 32'(k), 4'hF, 0, 1);
            eb.push_back({4'hF, 32'h1000_0000 + 32'(k)});
        end
        for (int c = 0; c < 12; c++) begin
            b_step(0, 0, 0, 0, 0);
            wr_seq[c] = b_wr;
        end
        chk("b_burst_wr_pattern", 64'(wr_seq), 64'(12'b1000_0111_0000));
        for (int k = 0; k < 3; k++) b_step(0, 0, 0, 0, 1);
        cmp_qb("b_burst");

        // ---- B: short final word with tx_last, then a new burst incl. be=0 word
        b_step(1, 32'hAABB_CCDD, 4'b1111, 0, 1);
        b_step(1, 32'h0000_00EE, 4'b0001, 1, 1);
        b_step(1, 32'h1111_1111, 4'b1111, 0, 1);
        b_step(1, 32'h2222_2222, 4'b1111, 0, 1);
        b_step(1, 32'h3333_3333, 4'b0000, 0, 1);
        eb.push_back({4'b1111, 32'hAABB_CCDD});
        eb.push_back({4'b0001, 32'h0000_00EE});
        eb.push_back({4'b1111, 32'h1111_1111});
        eb.push_back({4'b1111, 32'h2222_2222});
        eb.push_back({4'b0000, 32'h3333_3333});
        b_step(0, 0, 0, 0, 0);
        chk("b_pkt_word0", 64'({b_wr, b_be, b_data}), 64'({1'b0, 4'hF, 32'hAABB_CCDD}));
        b_step(0, 0, 0, 0, 0);
        chk("b_pkt_word1", 64'({b_wr, b_be, b_data}), 64'({1'b0, 4'h1, 32'h0000_00EE}));
        b_step(0, 0, 0, 0, 0);
        chk("b_pkt_end", 64'({b_wr, b_level}), 64'h13);
        b_step(0, 0, 0, 0, 0);
        b_step(0, 0, 0, 0, 0);
        b_step(0, 0, 0, 0, 0);
        chk("b_pkt_next_burst", 64'({b_wr, b_data}), 64'({1'b0, 32'h1111_1111}));
        for (int k = 0; k < 3; k++) b_step(0, 0, 0, 0, 0);
        chk("b_pkt_drained", 64'({b_wr, b_level}), 64'h10);
        b_step(0, 0, 0, 0, 1);
        cmp_qb("b_pkt");

`ifdef FT_TX_STATS_EN
        // ---- A: statistics, 10 transfers with 4 stall cycles
        a_rst = 1'b0;
        a_step(0, 0, 1);
        a_step(0, 0, 1);
        a_rst = 1'b1;
        chk("stat_reset", 64'({a_sw, a_ss}), 64'h0);
        for (int k = 1; k <= 8; k++) a_step(1, 16'(k), 1);
        txe_pat = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        for (int c = 0; c < 21; c++) a_step(0, 0, txe_pat[c] != 0);
        a_step(0, 0, 1);
        a_step(1, 16'd9, 1);
        a_step(1, 16'd10, 1);
        for (int c = 0; c < 3; c++) a_step(0, 0, 0);
        chk("stat_words", 64'(a_sw), 64'd10);
        chk("stat_stalls", 64'(a_ss), 64'd4);
        for (int k = 1; k <= 10; k++) ea.push_back(16'(k));
        cmp_qa("a_stats");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
